// File: rtl/regs_bus_arbiter_pkg.sv
// Shared definitions for the two-core register-bus arbiter: FSM states,
// owner encoding, default bus widths and the round-robin pick helper.
package regs_bus_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 22;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_ACK   = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // A lone requester wins; on contention the pointer decides (0 favours A).
  function automatic owner_e rr_pick(input logic a_req, input logic b_req, input logic ptr);
    if (a_req && b_req) return owner_e'(ptr);
    else if (b_req)     return OWNER_B;
    else                return OWNER_A;
  endfunction

endpackage

// File: rtl/regs_bus_arbiter.sv
// Two-core register-bus arbiter: IDLE -> ISSUE -> ACK, one transaction per 3 cycles.
// Optional bus locking is compiled in when the macro ARB_LOCK_EN is defined.
module regs_bus_arbiter
  import regs_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              owner,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  owner_e            grant_id;
  logic              grant_valid;
  logic              rr_ptr_q;
  logic              lock_q;
  logic              owner_req;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              we_q, re_q;
  logic              a_ack_q, b_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  assign sel_wr    = (grant_id == OWNER_B) ? b_wr    : a_wr;
  assign sel_addr  = (grant_id == OWNER_B) ? b_addr  : a_addr;
  assign sel_wdata = (grant_id == OWNER_B) ? b_wdata : a_wdata;
  assign owner_req = (owner_q  == OWNER_B) ? b_req   : a_req;

`ifdef ARB_LOCK_EN
  logic grantee_lock;
  assign grantee_lock = (owner_q == OWNER_B) ? b_lock : a_lock;

  // The flag follows the grantee's lock at every ACK and is released early
  // when the owner stops requesting, letting the other core in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_ACK) begin
      lock_q <= grantee_lock;
    end else if (state_q == ST_IDLE && lock_q && !owner_req) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign lock_q      = 1'b0;
  assign unused_lock = a_lock ^ b_lock;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and infers a latch.
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_id    = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_q && owner_req) begin
          grant_valid = 1'b1;
          grant_id    = owner_q;
        end else if (a_req || b_req) begin
          grant_valid = 1'b1;
          grant_id    = rr_pick(a_req, b_req, rr_ptr_q);
        end
        if (grant_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus-side registers: strobes live only in ISSUE, acks only in ACK, and
  // addr/write_data hold the last issued values while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q   <= OWNER_A;
      rr_ptr_q  <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q  <= grant_id;
            rr_ptr_q <= (grant_id == OWNER_A);
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            we_q     <= sel_wr;
            re_q     <= !sel_wr;
          end
        end
        ST_ISSUE: begin
          we_q <= 1'b0;
          re_q <= 1'b0;
          if (re_q) begin
            if (owner_q == OWNER_B) b_rdata_q <= read_data;
            else                    a_rdata_q <= read_data;
          end
          a_ack_q <= (owner_q == OWNER_A);
          b_ack_q <= (owner_q == OWNER_B);
        end
        ST_ACK: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
        end
        default: begin
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;
  assign we         = we_q;
  assign re         = re_q;
  assign owner      = owner_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Self-checking bench for regs_bus_arbiter: transaction-level model, per-cycle
// compare, and directed scenarios with literal expectations.
module tb_regs_bus_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_req = 1'b0, b_req = 1'b0;
  logic              a_wr = 1'b0, b_wr = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_lock = 1'b0, b_lock = 1'b0;
  logic              a_ack, b_ack;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] addr;
  logic              we, re;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              owner, busy;

  regs_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .addr(addr), .we(we), .re(re), .write_data(write_data), .read_data(read_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT.
  logic [DATA_W-1:0] regfile [16] = '{32'h00, 32'h11, 32'h22, 32'h33, 32'h55, 32'h55, 32'h66, 32'h77,
                                      32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hEE, 32'hFF};
  assign read_data = regfile[addr[3:0]];
  always @(posedge clk) if (we) regfile[addr[3:0]] <= write_data;

  // Transaction-level model: phase 0 idle, 1 strobe cycle, 2 ack cycle.
  int                m_phase = 0;
  int                cyc = 0;
  bit                m_who, m_wr, m_owner, m_favor_b, m_lock, have, w;
  logic [1:0]        rq;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata [2] = '{32'h0, 32'h0};
  logic [DATA_W-1:0] m_mem [16] = '{32'h00, 32'h11, 32'h22, 32'h33, 32'h55, 32'h55, 32'h66, 32'h77,
                                    32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hEE, 32'hFF};
  bit                grant_log [$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_favor_b = 0; m_lock = 0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_phase == 0) begin
      rq = {b_req, a_req};
      have = 0;
      w = 0;
      if (LOCK_EN && m_lock) begin
        if (rq[m_owner]) begin have = 1; w = m_owner; end
        else m_lock = 0;
      end
      if (!have && rq != 2'b00) begin
        have = 1;
        w = (rq == 2'b11) ? m_favor_b : rq[1];
      end
      if (have) begin
        m_who = w; m_owner = w; m_favor_b = !w;
        m_wr    = w ? b_wr    : a_wr;
        m_addr  = w ? b_addr  : a_addr;
        m_wdata = w ? b_wdata : a_wdata;
        grant_log.push_back(w);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_wr) m_mem[m_addr[3:0]] = m_wdata;
      else      m_rdata[m_who] = m_mem[m_addr[3:0]];
      m_phase = 2;
    end else begin
      if (LOCK_EN) m_lock = m_who ? b_lock : a_lock;
      m_phase = 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;
  int we_cnt = 0, re_cnt = 0;
  int ack_times [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_outputs();
    if (!cmp_en) return;
    check("busy",       busy,       m_phase != 0);
    check("we",         we,         m_phase == 1 && m_wr);
    check("re",         re,         m_phase == 1 && !m_wr);
    check("we_re_excl", we & re,    0);
    check("a_ack",      a_ack,      m_phase == 2 && !m_who);
    check("b_ack",      b_ack,      m_phase == 2 && m_who);
    check("owner",      owner,      m_owner);
    check("addr",       addr,       m_addr);
    check("write_data", write_data, m_wdata);
    check("a_rdata",    a_rdata,    m_rdata[0]);
    check("b_rdata",    b_rdata,    m_rdata[1]);
    if (we) we_cnt++;
    if (re) re_cnt++;
    if (a_ack || b_ack) ack_times.push_back(cyc);
  endtask

  // One cycle: compare at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 0; a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
    step();
    cmp_en = 1;
    step();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int  base, ab, we0, re0, acks, a_acks;
  bit  done;

  initial begin
    apply_reset();
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);

    // Lone read of A at address 4.
    a_req = 1; a_wr = 0; a_addr = 4;
    step();
    check("r35_re", re, 1);
    check("r35_addr", addr, 4);
    check("r35_ack_early", a_ack, 0);
    step();
    check("r35_ack", a_ack, 1);
    check("r35_re_off", re, 0);
    check("r35_rdata", a_rdata, 32'h55);
    a_req = 0;
    step(); step();

    // Simultaneous A write and B read from reset.
    apply_reset();
    base = grant_log.size(); we0 = we_cnt; re0 = re_cnt;
    a_req = 1; a_wr = 1; a_addr = 3; a_wdata = 32'h41;
    b_req = 1; b_wr = 0; b_addr = 2;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (a_ack) a_req = 0;
      if (b_ack) b_req = 0;
      done = !a_req && !b_req;
    end
    check("r36_done", done, 1);
    step(); step();
    check("r36_ngrants", grant_log.size() - base, 2);
    if (grant_log.size() >= base + 2) begin
      check("r36_first_A", grant_log[base], 0);
      check("r36_second_B", grant_log[base+1], 1);
    end
    check("r36_we_cnt", we_cnt - we0, 1);
    check("r36_re_cnt", re_cnt - re0, 1);
    check("r36_regfile3", regfile[3], 32'h41);
    check("r36_b_rdata", b_rdata, 32'h22);

    // Both hold requests for six transactions.
    apply_reset();
    base = grant_log.size(); ab = ack_times.size();
    a_req = 1; a_wr = 0; a_addr = 1;
    b_req = 1; b_wr = 0; b_addr = 2;
    acks = 0;
    for (int i = 0; i < 40 && acks < 6; i++) begin
      step();
      if (a_ack || b_ack) acks++;
    end
    a_req = 0; b_req = 0;
    check("r37_acks", acks, 6);
    step(); step(); step();
    check("r37_ngrants", grant_log.size() - base, 6);
    for (int k = 0; k < 6; k++)
      if (grant_log.size() > base + k) check("r37_alternate", grant_log[base+k], k % 2);
    for (int k = 1; k < 6; k++)
      if (ack_times.size() > ab + k) check("r37_ack_spacing", ack_times[ab+k] - ack_times[ab+k-1], 3);

    // Reset during the strobe cycle of a B write.
    apply_reset();
    ab = ack_times.size(); we0 = we_cnt; re0 = re_cnt;
    b_req = 1; b_wr = 1; b_addr = 5; b_wdata = 32'h99;
    step();
    check("r38_we", we, 1);
    check("r38_owner_b", owner, 1);
    rst_n = 0; b_req = 0;
    step();
    check("r38_rst_we", we, 0);
    check("r38_rst_owner", owner, 0);
    check("r38_rst_busy", busy, 0);
    check("r38_rst_addr", addr, 0);
    check("r38_rst_wdata", write_data, 0);
    check("r38_rst_b_ack", b_ack, 0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) step();
    check("r38_no_ack", ack_times.size() - ab, 0);
    check("r38_one_strobe", we_cnt - we0, 1);
    check("r38_no_read", re_cnt - re0, 0);

    // Request withdrawn mid-transaction still completes; then read it back.
    apply_reset();
    a_req = 1; a_wr = 1; a_addr = 8; a_wdata = 32'hC3;
    step();
    a_req = 0;
    step();
    check("r26_ack", a_ack, 1);
    step(); step();
    b_req = 1; b_wr = 0; b_addr = 8;
    step(); step();
    check("r26_b_ack", b_ack, 1);
    check("r26_b_rdata", b_rdata, 32'hC3);
    b_req = 0;
    step(); step();

    // A reads with lock while B keeps requesting.
    apply_reset();
    base = grant_log.size(); ab = ack_times.size();
    a_req = 1; a_wr = 0; a_addr = 6; a_lock = 1;
    b_req = 1; b_wr = 0; b_addr = 7;
    acks = 0; a_acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      step();
      if (a_ack) a_acks++;
      if (a_ack || b_ack) acks++;
      if (a_acks >= 2 && !a_ack) a_lock = 0;
      if (a_acks == 3 || acks == 4) a_req = 0;
      if (acks == 4) b_req = 0;
    end
    check("r39_acks", acks, 4);
    step(); step(); step();
    check("r39_ngrants", grant_log.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (grant_log.size() > base + k) begin
        if (LOCK_EN) check("r39_locked_order", grant_log[base+k], k == 3);
        else         check("r40_alternate", grant_log[base+k], k % 2);
      end
    end
    for (int k = 1; k < 4; k++)
      if (ack_times.size() > ab + k) check("r39_ack_spacing", ack_times[ab+k] - ack_times[ab+k-1], 3);
    check("r39_a_rdata", a_rdata, 32'h66);
    check("r39_b_rdata", b_rdata, 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
